// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register and its burst controller.
// Holds the manual-mode codes, burst FSM states and burst directions.
package usr_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst engine: IDLE/SHIFT/DONE FSM plus a down-counter of remaining shifts.
// Ports: i_start/i_shift_cnt/i_dir request a burst; o_shift/o_dir strobe one
// shift per SHIFT cycle; o_busy, o_done and o_idle are registered state decodes.
module usr_burst_ctrl
    import usr_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_shift_cnt,
    input  logic             i_dir,
    output logic             o_shift,
    output logic             o_dir,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_idle
);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;

    state_e           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_dir_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dir   <= DIR_RIGHT;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_shift_cnt != '0) begin
                        w_state_nxt = ST_SHIFT;
                        w_cnt_nxt   = i_shift_cnt;
                        w_dir_nxt   = i_dir;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                // The shift for this cycle lands on the same edge that
                // leaves SHIFT when this is the final one.
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_shift = (r_state == ST_SHIFT);
    assign o_dir   = r_dir;
    assign o_busy  = (r_state == ST_SHIFT);
    assign o_done  = (r_state == ST_DONE);
    assign o_idle  = (r_state == ST_IDLE);

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / load, serial
// in and out at both ends, plus an autonomous N-shift burst engine.
// Ports: en+mode manual op, pdin load data, sin_r/sin_l serial in,
// start/shift_cnt/dir burst request, pdout/sout_r/sout_l data out,
// busy/done burst status. Define USR_ROTATE_EN to add the rot port.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] pdin,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             start,
    input  logic [CNT_W-1:0] shift_cnt,
    input  logic             dir,
`ifdef USR_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] pdout,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] r_pdout;
    logic [WIDTH-1:0] w_pdout_nxt;
    logic             w_shift;
    logic             w_dir;
    logic             w_idle;
    logic             w_in_r;
    logic             w_in_l;

    usr_burst_ctrl #(
        .CNT_W(CNT_W)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .i_start    (start),
        .i_shift_cnt(shift_cnt),
        .i_dir      (dir),
        .o_shift    (w_shift),
        .o_dir      (w_dir),
        .o_busy     (busy),
        .o_done     (done),
        .o_idle     (w_idle)
    );

`ifdef USR_ROTATE_EN
    assign w_in_r = rot ? r_pdout[0]       : sin_r;
    assign w_in_l = rot ? r_pdout[WIDTH-1] : sin_l;
`else
    assign w_in_r = sin_r;
    assign w_in_l = sin_l;
`endif

    always_comb begin
        w_pdout_nxt = r_pdout;
        if (w_shift) begin
            if (w_dir == DIR_LEFT) begin
                w_pdout_nxt = {r_pdout[WIDTH-2:0], w_in_l};
            end else begin
                w_pdout_nxt = {w_in_r, r_pdout[WIDTH-1:1]};
            end
        end else if (w_idle && !start && en) begin
            // A burst request in IDLE takes priority over a manual op.
            unique case (mode)
                MODE_SHR:  w_pdout_nxt = {w_in_r, r_pdout[WIDTH-1:1]};
                MODE_SHL:  w_pdout_nxt = {r_pdout[WIDTH-2:0], w_in_l};
                MODE_LOAD: w_pdout_nxt = pdin;
                default:   w_pdout_nxt = r_pdout;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pdout <= '0;
        end else begin
            r_pdout <= w_pdout_nxt;
        end
    end

    assign pdout  = r_pdout;
    assign sout_r = r_pdout[0];
    assign sout_l = r_pdout[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios plus random
// traffic, checked against a queue-of-pending-operations reference model.
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [W-1:0]  pdin = '0;
    logic          sin_r = 1'b0;
    logic          sin_l = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] shift_cnt = '0;
    logic          dir = 1'b0;
    logic          rot = 1'b0;
    logic [W-1:0]  pdout;
    logic          sout_r;
    logic          sout_l;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_bad = 0;

    typedef enum int {OP_R, OP_L, OP_DONE} op_e;
    op_e ops[$];
    int  m_v;

    always #5 clk = ~clk;

    univ_shift_reg #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .pdin     (pdin),
        .sin_r    (sin_r),
        .sin_l    (sin_l),
        .start    (start),
        .shift_cnt(shift_cnt),
        .dir      (dir),
`ifdef USR_ROTATE_EN
        .rot      (rot),
`endif
        .pdout    (pdout),
        .sout_r   (sout_r),
        .sout_l   (sout_l),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit rot_on();
`ifdef USR_ROTATE_EN
        return rot;
`else
        return 1'b0;
`endif
    endfunction

    task automatic m_shr();
        int b;
        b = rot_on() ? (m_v & 1) : int'(sin_r);
        m_v = (m_v >> 1) | (b << (W - 1));
    endtask

    task automatic m_shl();
        int b;
        b = rot_on() ? ((m_v >> (W - 1)) & 1) : int'(sin_l);
        m_v = ((m_v << 1) & ((1 << W) - 1)) | b;
    endtask

    // A burst is the list of shifts still owed followed by one done cycle.
    task automatic m_edge();
        op_e o;
        if (rst) begin
            m_v = 0;
            ops.delete();
        end else if (ops.size() > 0) begin
            o = ops.pop_front();
            if (o == OP_R) m_shr();
            else if (o == OP_L) m_shl();
        end else if (start) begin
            for (int i = 0; i < int'(shift_cnt); i++)
                ops.push_back(dir ? OP_L : OP_R);
            ops.push_back(OP_DONE);
        end else if (en) begin
            case (mode)
                2'b01: m_shr();
                2'b10: m_shl();
                2'b11: m_v = int'(pdin);
                default: ;
            endcase
        end
    endtask

    task automatic check_all();
        bit eb, ed;
        eb = (ops.size() > 0) && (ops[0] != OP_DONE);
        ed = (ops.size() > 0) && (ops[0] == OP_DONE);
        chk("pdout", 32'(pdout), 32'(m_v));
        chk("sout_r", 32'(sout_r), 32'(m_v & 1));
        chk("sout_l", 32'(sout_l), 32'((m_v >> (W - 1)) & 1));
        chk("busy", 32'(busy), 32'(eb));
        chk("done", 32'(done), 32'(ed));
    endtask

    task automatic cyc();
        @(posedge clk);
        m_edge();
        #1;
        check_all();
    endtask

    task automatic load(input logic [W-1:0] v);
        en = 1'b1; mode = 2'b11; pdin = v; start = 1'b0;
        cyc();
        en = 1'b0;
    endtask

    initial begin
        m_v = 0;
        // reset over two edges with a pending load
        rst = 1'b1; pdin = 8'hFF; mode = 2'b11; en = 1'b1;
        cyc();
        cyc();
        chk("rst_pdout", 32'(pdout), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        rst = 1'b0;

        // manual load, shift right, shift left
        load(8'hA5);
        en = 1'b1; mode = 2'b01; sin_r = 1'b1;
        cyc();
        chk("shr_val", 32'(pdout), 32'hD2);
        chk("shr_sout_r", 32'(sout_r), 32'h0);
        mode = 2'b10; sin_l = 1'b0;
        cyc();
        chk("shl_val", 32'(pdout), 32'hA4);
        en = 1'b0;

        // burst left by 3; manual inputs must be ignored while busy
        load(8'h81);
        start = 1'b1; dir = 1'b1; shift_cnt = 4'd3; sin_l = 1'b0;
        cyc();
        start = 1'b0; en = 1'b1; mode = 2'b11; pdin = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            chk("burst_busy", 32'(busy), 32'h1);
            if (i < 2) cyc();
        end
        en = 1'b0;
        cyc();
        chk("burst_val", 32'(pdout), 32'h08);
        chk("burst_done", 32'(done), 32'h1);
        chk("burst_busy_off", 32'(busy), 32'h0);
        cyc();
        chk("burst_done_off", 32'(done), 32'h0);

        // zero-length burst beats a simultaneous load
        start = 1'b1; shift_cnt = 4'd0; en = 1'b1; mode = 2'b11; pdin = 8'hFF;
        cyc();
        start = 1'b0; en = 1'b0;
        chk("zero_done", 32'(done), 32'h1);
        chk("zero_busy", 32'(busy), 32'h0);
        chk("zero_val", 32'(pdout), 32'h08);
        cyc();

        // reset in the second cycle of a 5-shift burst
        load(8'h3C);
        start = 1'b1; dir = 1'b0; shift_cnt = 4'd5;
        cyc();
        start = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("abort_val", 32'(pdout), 32'h00);
        chk("abort_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("abort_no_done", 32'(done), 32'h0);
        end
        start = 1'b1; dir = 1'b0; shift_cnt = 4'd2; sin_r = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        chk("after_val", 32'(pdout), 32'hC0);
        chk("after_done", 32'(done), 32'h1);
        cyc();

`ifdef USR_ROTATE_EN
        rot = 1'b1; sin_r = 1'b0;
        load(8'h01);
        start = 1'b1; dir = 1'b0; shift_cnt = 4'd1;
        cyc();
        start = 1'b0;
        cyc();
        chk("rot1_val", 32'(pdout), 32'h80);
        cyc();
        start = 1'b1; shift_cnt = 4'd8;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 8; i++) cyc();
        chk("rot8_val", 32'(pdout), 32'h80);
        chk("rot8_done", 32'(done), 32'h1);
        cyc();
        rot = 1'b0;
`endif

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 99) < 2);
            en        = 1'($urandom_range(0, 1));
            mode      = 2'($urandom_range(0, 3));
            pdin      = 8'($urandom);
            sin_r     = 1'($urandom_range(0, 1));
            sin_l     = 1'($urandom_range(0, 1));
            start     = ($urandom_range(0, 99) < 10);
            shift_cnt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(0, 3));
            dir       = 1'($urandom_range(0, 1));
            rot       = 1'($urandom_range(0, 1));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
